wb_arb2_16: RTL and testbench
=============================

# wb_arb2_16

Two-master, one-slave 16-bit Wishbone arbiter that shares a single slave, typically the BRAM block, between two bus masters (e.g. DCPU16 core and a DMA/display fetch engine). Round-robin grant, held for the whole `cyc` of the winner. This supports locked multi-beat sequences. A per-grant watchdog turns a non-responding slave into a Wishbone `err` toward the master.

## Interface
- `TO_W`, 8: width of the watchdog counter.
- `TIMEOUT`, 255: cycles with `s_stb` high and no slave `ack`/`err`/`rty` before the arbiter issues `err`. Must be < 2^TO_W; 0 disables the watchdog.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `m0_adr`/`m1_adr`  in  16  master address.
- `m0_dat_i`/`m1_dat_i`  in  16  master write data.
- `m0_dat_o`/`m1_dat_o`  out  16  read data to master.
- `m0_cyc`/`m1_cyc`, `m0_stb`/`m1_stb`, `m0_we`/`m1_we`  in  1  master cycle, strobe, write enable.
- `m0_sel`/`m1_sel`  in  2  byte selects.
- `m0_ack`/`m1_ack`, `m0_err`/`m1_err`, `m0_rty`/`m1_rty`  out  1  termination signals to master.
- `s_adr` out 16; `s_dat_o` out 16; `s_dat_i` in 16; `s_cyc`, `s_stb`, `s_we` out 1; `s_sel` out 2; `s_ack`, `s_err`, `s_rty` in 1. These are the slave-side signals.
- `gnt`  out  2  one-hot current grant ({m1,m0}); 2'b00 when idle.

## Operation
- States: IDLE, GNT0, GNT1, all registered. `last` register holds the last granted master and resets to 1, so m0 wins the first tie.
- IDLE:
  - only `m0_cyc` high → GNT0.
  - only `m1_cyc` high → GNT1.
  - both high → grant the master ≠ `last`.
  - neither high → stay in IDLE.
- GNTx:
  - while `mx_cyc` stays high → stay, whatever the other master does. This is the lock.
  - `mx_cyc` low, other master's `cyc` high → go directly to the other grant, no idle bubble.
  - otherwise → IDLE.
  - `last` updates to x when GNTx is entered.
- Slave-side outputs are combinational muxes of the granted master's signals.
  - In IDLE, all slave outputs are 0.
  - `s_cyc`/`s_stb` are also forced 0 in the cycle a timeout `err` is issued.
- Master-side returns:
  - Granted master: `mx_ack = s_ack`, `mx_rty = s_rty`, `mx_err = s_err | to_err`, `mx_dat_o = s_dat_i`.
  - Non-granted master: all four are 0, `dat_o` = 16'h0.
- Watchdog (per grant):
  - Counter clears on any state change, any slave termination, or `s_stb` low.
  - Otherwise it increments while `s_stb` is high.
  - At count == TIMEOUT−1, the registered `to_err` pulses for exactly 1 cycle and the counter clears.
  - The master is expected to drop `stb` after an `err`.
- Slave termination and timeout in the same cycle: the slave termination wins, and `to_err` is not asserted.
- Reset mid-grant: state → IDLE, counter → 0, `to_err` → 0, `last` → 1. All outputs go to 0 immediately (async).

## Timing
- Reset values:
  - `gnt` = 0.
  - All `m*_ack`/`err`/`rty` = 0; all `m*_dat_o` = 0.
  - All `s_*` outputs = 0.
- Grant latency: the first `cyc` edge in IDLE is seen at clock edge N, and the grant is active from N onward. Slave sees `s_cyc`/`s_stb` in cycle N+1, i.e. 1 cycle of arbitration overhead.
- Handover latency: the other master's grant is active from the edge at which the owner's `cyc` is sampled low. This gives 0 idle cycles between owners.
- No added latency on the data/ack path; the arbiter's returns are combinational.
- With the BRAM slave:
  - write: ack one cycle after `s_stb`;
  - read: ack two cycles after `s_stb`;
  - each access is followed by one slave recovery cycle.
- `to_err` asserts TIMEOUT cycles after the first unanswered `s_stb` cycle.

## Test plan
- **Single master read:** m0 reads 16'h0010 (BRAM preloaded 16'hBEEF) → `gnt` = 01, `m0_ack` one pulse with `m0_dat_o` = 16'hBEEF; `m1_ack` = 0 throughout.
- **Simultaneous request after reset:** m0 and m1 raise `cyc` in the same cycle → m0 granted first. When m0 drops `cyc`, m1 is granted on the same edge, with `gnt` going 01→10 and no 00 cycle.
- **Round-robin:** both masters request continuously with single-beat writes (m0 writes 16'h1111 to 16'h0001, m1 writes 16'h2222 to 16'h0002) → grants alternate 01,10,01,10. Both addresses read back their values.
- **Lock:** m0 holds `cyc` over 3 writes (addresses 16'h0, 16'h1, 16'h2) while m1 requests → m1 is not granted until m0's `cyc` falls. m1's `ack`/`dat_o` stay 0 until its grant.
- **Watchdog (TIMEOUT=4):** dummy slave never acks → `m0_err` pulses 1 cycle exactly 4 cycles after `s_stb` rises, with `s_stb` = 0 in that cycle. Repeat with the slave acking in the 4th cycle → no `err`.
- **Reset mid-operation:** assert `rst` during an m1 read → `gnt`, `s_cyc`, and all `ack`s go to 0 asynchronously. After release, with both requesting, m0 is granted first.

Source files
------------

// File: rtl/wb_arb2_16.sv
// wb_arb2_16: two-master round-robin Wishbone arbiter sharing one 16-bit slave.
//   clk, rst        : clock, asynchronous active-high reset
//   m0_*, m1_*      : master ports (adr, dat_i, cyc, stb, we, sel in; dat_o, ack, err, rty out)
//   s_*             : slave port, a combinational mux of the granted master
//   gnt             : one-hot grant {m1,m0}, 2'b00 when idle
// The winner keeps the slave for its whole cyc; a per-grant watchdog turns a
// silent slave into an err towards the owning master.
module wb_arb2_16 #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] m0_adr,
    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [1:0]  m0_sel,
    output logic        m0_ack,
    output logic        m0_err,
    output logic        m0_rty,
    input  logic [15:0] m1_adr,
    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [1:0]  m1_sel,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        m1_rty,
    output logic [15:0] s_adr,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [1:0]  s_sel,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic        s_rty,
    output logic [1:0]  gnt
);
    localparam logic [1:0] IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2;

    logic [1:0]      state, state_nxt;
    logic            last, to_err, hit, hold, pick0, chg, g0, g1, term;
    logic [TO_W-1:0] cnt;

    assign g0 = state == GNT0;
    assign g1 = state == GNT1;
    // the owner keeps the grant as long as its cyc stays high (bus lock)
    assign hold = (g0 && m0_cyc) || (g1 && m1_cyc);
    // m0 wins from IDLE when alone or when m1 was served last; after m1 releases it is the only candidate
    assign pick0 = m0_cyc && (g1 || (state == IDLE && (!m1_cyc || last)));
    assign state_nxt = hold ? state : pick0 ? GNT0 : m1_cyc ? GNT1 : IDLE;
    assign chg = state_nxt != state;

    assign s_adr   = g0 ? m0_adr : g1 ? m1_adr : '0;
    assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    assign s_sel   = g0 ? m0_sel : g1 ? m1_sel : '0;
    assign s_we    = g0 ? m0_we : g1 && m1_we;
    // the cycle carrying a timeout err withdraws the request from the slave
    assign s_cyc   = !to_err && (g0 ? m0_cyc : g1 && m1_cyc);
    assign s_stb   = !to_err && (g0 ? m0_stb : g1 && m1_stb);

    assign term = s_ack || s_err || s_rty;
    // a real slave termination in the last watchdog cycle beats the timeout
    assign hit  = TIMEOUT != 0 && s_stb && !term && !chg && cnt == TO_W'(TIMEOUT - 1);

    assign m0_ack   = g0 && s_ack;
    assign m0_rty   = g0 && s_rty;
    assign m0_err   = g0 && (s_err || to_err);
    assign m0_dat_o = g0 ? s_dat_i : '0;
    assign m1_ack   = g1 && s_ack;
    assign m1_rty   = g1 && s_rty;
    assign m1_err   = g1 && (s_err || to_err);
    assign m1_dat_o = g1 ? s_dat_i : '0;
    assign gnt      = {g1, g0};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= IDLE;
            last   <= 1'b1;
            to_err <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            last   <= chg && state_nxt != IDLE ? state_nxt == GNT1 : last;
            to_err <= hit;
            cnt    <= chg || term || !s_stb || hit ? '0 : cnt + TO_W'(1);
        end
endmodule

// File: tb/tb_wb_arb2_16.sv
// tb_wb_arb2_16: table-driven scoreboard bench for wb_arb2_16 with a BRAM-like slave model.
module tb_wb_arb2_16;
    typedef struct {
        int          grp;
        int          m;
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
        logic        hold;
        logic [15:0] exp_dat;
        logic        exp_err;
        int          smode;
    } vec_t;

    localparam int NV = 19;

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  cyc = '0, stb = '0, we = '0, ack, err, rty, gnt;
    logic [15:0] adr [2], mdat [2], dat_o [2];
    logic [1:0]  sel [2];
    logic [15:0] s_adr, s_dat_o, s_dat_i;
    logic        s_cyc, s_stb, s_we, s_ack, s_err, rec, pstb, err_stb;
    logic [1:0]  s_sel;
    logic [15:0] mem [256];
    int          scnt, smode, ntests, nfail, tcyc, rise, errc;
    int          dcyc [2], ackc [2];
    vec_t        tbl [NV];
    vec_t        cmdq [2][$];
    vec_t        sbq [2][$];
    logic [1:0]  glog [$];

    always #5 clk = ~clk;

    wb_arb2_16 #(.TO_W(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_adr(adr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(dat_o[0]), .m0_cyc(cyc[0]), .m0_stb(stb[0]),
        .m0_we(we[0]), .m0_sel(sel[0]), .m0_ack(ack[0]), .m0_err(err[0]), .m0_rty(rty[0]),
        .m1_adr(adr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(dat_o[1]), .m1_cyc(cyc[1]), .m1_stb(stb[1]),
        .m1_we(we[1]), .m1_sel(sel[1]), .m1_ack(ack[1]), .m1_err(err[1]), .m1_rty(rty[1]),
        .s_adr(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_cyc(s_cyc), .s_stb(s_stb),
        .s_we(s_we), .s_sel(s_sel), .s_ack(s_ack), .s_err(s_err), .s_rty(1'b0), .gnt(gnt)
    );

    // slave: mode 0 BRAM (write ack after 1 cycle, read after 2, one recovery cycle),
    // mode 1 never answers, mode 2 acks in the 4th stb cycle, mode 3 errs after 1 cycle
    assign s_ack = s_stb && !rec && (smode == 0 ? scnt == (s_we ? 1 : 2) : smode == 2 && scnt == 3);
    assign s_err = s_stb && smode == 3 && scnt == 1;
    assign s_dat_i = (s_ack && !s_we) ? mem[s_adr[7:0]] : 16'h0;

    always @(posedge clk)
        if (rst) begin
            mem[8'h10] <= 16'hBEEF;
            scnt <= 0;
            rec <= 1'b0;
        end else begin
            rec <= s_ack || s_err;
            scnt <= (s_stb && !s_ack && !s_err) ? scnt + 1 : 0;
            if (s_ack && s_we) mem[s_adr[7:0]] <= s_dat_o;
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    function automatic string gseq();
        string s = "";
        logic [1:0] p = 2'b11;
        foreach (glog[k])
            if (glog[k] !== p) begin
                s = {s, $sformatf("%b ", glog[k])};
                p = glog[k];
            end
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cyc = '0;
        stb = '0;
        we = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // drives both masters from their command queues, one beat at a time with a
    // one-cycle gap after each beat, and scores every termination
    task automatic run(input int budget);
        int n, tail;
        logic [1:0] busy, gap, ncyc, nstb, nwe;
        logic [15:0] nadr [2], ndat [2];
        vec_t e;
        n = 0; tail = 0; busy = '0; gap = '0;
        ncyc = cyc; nstb = stb; nwe = we; nadr = adr; ndat = mdat;
        glog.delete();
        rise = -1; errc = -1; ackc[0] = -1; ackc[1] = -1; err_stb = 1'b1; pstb = 1'b0;
        while (tail < 3 && n < budget) begin
            @(negedge clk);
            n++;
            tcyc++;
            glog.push_back(gnt);
            if (s_stb && !pstb && rise < 0) rise = tcyc;
            pstb = s_stb;
            if (gnt == 2'b00) chk("idle_slave", {s_cyc, s_stb, s_we, s_sel, s_adr, |s_dat_o}, 0);
            for (int i = 0; i < 2; i++) begin
                if (!gnt[i]) chk($sformatf("idle_ret_m%0d", i), {ack[i], err[i], rty[i], dat_o[i]}, 0);
                else chk($sformatf("s_adr_m%0d", i), s_adr, adr[i]);
                if (busy[i]) begin
                    if (ack[i] || err[i]) begin
                        e = sbq[i].pop_front();
                        chk($sformatf("err_m%0d_%0h", i, e.adr), err[i], e.exp_err);
                        if (!e.exp_err && !e.we) chk($sformatf("rd_m%0d_%0h", i, e.adr), dat_o[i], e.exp_dat);
                        if (err[i] && errc < 0) begin
                            errc = tcyc;
                            err_stb = s_stb;
                        end
                        if (ack[i]) ackc[i] = tcyc;
                        busy[i] = 1'b0; nstb[i] = 1'b0; ncyc[i] = e.hold; gap[i] = 1'b1;
                    end else if (tcyc - dcyc[i] > 40) begin
                        ntests++; nfail++;
                        $display("FAIL m%0d_timeout: no termination after 40 cycles", i);
                        sbq[i].delete();
                        busy[i] = 1'b0; nstb[i] = 1'b0; ncyc[i] = 1'b0;
                    end
                end else if (gap[i]) gap[i] = 1'b0;
                else if (cmdq[i].size() != 0) begin
                    e = cmdq[i].pop_front();
                    sbq[i].push_back(e);
                    busy[i] = 1'b1; dcyc[i] = tcyc + 1;
                    ncyc[i] = 1'b1; nstb[i] = 1'b1; nwe[i] = e.we; nadr[i] = e.adr; ndat[i] = e.dat;
                end
            end
            tail = (busy == 2'b00 && cmdq[0].size() == 0 && cmdq[1].size() == 0) ? tail + 1 : 0;
            @(posedge clk);
            #1;
            cyc = ncyc; stb = nstb; we = nwe; adr = nadr; mdat = ndat;
        end
        if (n >= budget) begin
            ntests++; nfail++;
            $display("FAIL run_budget: %0d cycles used", n);
        end
    endtask

    initial begin
        //        grp m  we    adr       dat       hold  exp_dat   exp_err smode
        tbl = '{'{0, 0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 0},
                '{1, 0, 1'b1, 16'h0020, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 0},
                '{1, 1, 1'b1, 16'h0021, 16'h5555, 1'b0, 16'h0000, 1'b0, 0},
                '{2, 0, 1'b1, 16'h0001, 16'h1111, 1'b0, 16'h0000, 1'b0, 0},
                '{2, 0, 1'b1, 16'h0001, 16'h1111, 1'b0, 16'h0000, 1'b0, 0},
                '{2, 0, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'h1111, 1'b0, 0},
                '{2, 1, 1'b1, 16'h0002, 16'h2222, 1'b0, 16'h0000, 1'b0, 0},
                '{2, 1, 1'b1, 16'h0002, 16'h2222, 1'b0, 16'h0000, 1'b0, 0},
                '{2, 1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h2222, 1'b0, 0},
                '{3, 0, 1'b1, 16'h0000, 16'hA000, 1'b1, 16'h0000, 1'b0, 0},
                '{3, 0, 1'b1, 16'h0001, 16'hA001, 1'b1, 16'h0000, 1'b0, 0},
                '{3, 0, 1'b1, 16'h0002, 16'hA002, 1'b0, 16'h0000, 1'b0, 0},
                '{3, 1, 1'b1, 16'h0003, 16'hB003, 1'b0, 16'h0000, 1'b0, 0},
                '{4, 1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'hA002, 1'b0, 0},
                '{4, 0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hA000, 1'b0, 0},
                '{4, 1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'hB003, 1'b0, 0},
                '{5, 0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, 1},
                '{6, 0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 2},
                '{7, 1, 1'b1, 16'h0030, 16'h1234, 1'b0, 16'h0000, 1'b1, 3}};
        ntests = 0; nfail = 0; tcyc = 0; smode = 0;
        sel[0] = 2'b11; sel[1] = 2'b11;
        adr[0] = '0; adr[1] = '0; mdat[0] = '0; mdat[1] = '0;
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_slave", {s_cyc, s_stb, s_we, s_sel, s_adr}, 0);
        chk("rst_sdat", s_dat_o, 0);
        chk("rst_ret", {ack, err, rty}, 0);
        chk("rst_dat0", dat_o[0], 0);
        chk("rst_dat1", dat_o[1], 0);
        for (int g = 0; g < 8; g++) begin
            do_reset();
            foreach (tbl[k])
                if (tbl[k].grp == g) begin
                    cmdq[tbl[k].m].push_back(tbl[k]);
                    smode = tbl[k].smode;
                end
            run(300);
            chk($sformatf("sb_empty_g%0d", g), sbq[0].size() + sbq[1].size(), 0);
            if (g == 0) begin
                chk_s("single_gnt", gseq(), "00 01 00 ");
                chk("grant_latency", rise - dcyc[0], 1);
            end else if (g == 1) begin
                chk_s("tie_gnt", gseq(), "00 01 10 00 ");
                chk("tie_order", ackc[0] < ackc[1], 1);
            end else if (g == 2) chk_s("rr_gnt", gseq(), "00 01 10 01 10 01 10 00 ");
            else if (g == 3) chk_s("lock_gnt", gseq(), "00 01 10 00 ");
            else if (g == 5) begin
                chk("wd_delay", errc - rise, 4);
                chk("wd_stb", err_stb, 0);
            end else if (g == 6) begin
                chk("wd_ack_delay", ackc[0] - rise, 3);
                chk("wd_no_err", errc, 32'hFFFF_FFFF);
            end
        end
        do_reset();
        smode = 0;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        chk("mid_gnt", gnt, 2'b10);
        for (int k = 0; k < 8 && !ack[1]; k++) @(negedge clk);
        chk("mid_ack", ack[1], 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_slave", {s_cyc, s_stb}, 0);
        chk("arst_ret", {ack, err, rty}, 0);
        chk("arst_dat1", dat_o[1], 0);
        cyc = '0; stb = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 2'b11;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_gnt", gnt, 2'b01);
        cyc = '0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
